// File: rtl/lpm_inv_skid.sv
// lpm_inv_skid: two-entry skid buffer that stores each accepted word, optionally
// bit-inverted, and presents it on a registered ready/valid output.
// The head register M drives result. The skid register S catches the one word
// that can arrive while the head is stalled by the downstream side.
module lpm_inv_skid #(
  parameter string lpm_type   = "lpm_inv_skid",
  parameter int    lpm_width  = 1,
  parameter string lpm_invert = "ON",
  parameter string lpm_hint   = "UNUSED"
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic                 sclr,
  input  logic                 data_valid,
  input  logic [lpm_width-1:0] data,
  output logic                 data_ready,
  output logic                 result_valid,
  output logic [lpm_width-1:0] result,
  input  logic                 result_ready,
  output logic [1:0]           usedw
);

  // Reject configurations that cannot be built. The identification strings
  // only need to be non-empty.
  if ((lpm_width < 1) || (lpm_type == "") || (lpm_hint == "")) begin : g_cfg_error
    $error("lpm_inv_skid: lpm_width must be >= 1 and identification strings non-empty");
  end

  localparam bit INVERT = (lpm_invert == "ON");

  // The occupancy state doubles as the usedw encoding.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [lpm_width-1:0]   m_q, m_d;
  logic [lpm_width-1:0]   s_q, s_d;
  logic                   result_valid_q, result_valid_d;
  logic                   push;
  logic                   pop;

  // Data transform applied on the way into storage, never on the way out.
  function automatic logic [lpm_width-1:0] f_map(input logic [lpm_width-1:0] x);
    if (INVERT) begin
      f_map = ~x;
    end else begin
      f_map = x;
    end
  endfunction

  // data_ready is the only combinational output. It is forced low while the
  // asynchronous clear is active, so nothing is accepted during reset.
  assign data_ready = aclr_n & (state_q != ST_FULL);
  assign push       = data_valid & data_ready;
  assign pop        = result_valid_q & result_ready;

  // Next-state and datapath selection. sclr wins over any push or pop. A word
  // popped in the sclr cycle has already been delivered. A word pushed in the
  // sclr cycle is discarded. M and S load only on a push (or on the S->M move),
  // so an idle or X data bus never reaches storage.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (sclr) begin
      state_d = ST_EMPTY;
      m_d     = '0;
      s_d     = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            m_d     = f_map(data);
            state_d = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            m_d     = f_map(data);
            state_d = ST_ONE;
          end else if (push) begin
            s_d     = f_map(data);
            state_d = ST_FULL;
          end else if (pop) begin
            // M keeps its last value. It is simply no longer marked valid.
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (pop) begin
            m_d     = s_q;
            state_d = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty buffer.
          state_d = ST_EMPTY;
          m_d     = '0;
          s_d     = '0;
        end
      endcase
    end
    result_valid_d = (state_d != ST_EMPTY);
  end

  // State and storage registers, cleared immediately by aclr_n.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q        <= ST_EMPTY;
      m_q            <= '0;
      s_q            <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      m_q            <= m_d;
      s_q            <= s_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign result       = m_q;
  assign result_valid = result_valid_q;
  assign usedw        = state_q;

endmodule

// File: tb/tb_lpm_inv_skid.sv
// Scoreboard bench for lpm_inv_skid. It uses one 8-bit inverting instance and
// one 1-bit pass-through instance. Each drive task records the hand-computed
// expected word when its model says the word is accepted. Monitors on the
// falling edge compare occupancy, handshakes and data against that model.
module tb_lpm_inv_skid;

  logic       clock = 1'b0;
  logic       aclr_n;

  logic       sc8, dv8, dr8, rv8, rr8;
  logic [7:0] d8, res8;
  logic [1:0] uw8;

  logic       sc1, dv1, dr1, rv1, rr1;
  logic [0:0] d1, res1;
  logic [1:0] uw1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] q8[$];
  logic [0:0] q1[$];
  int         mc8 = 0;
  int         mc1 = 0;
  logic [7:0] e8;
  logic [0:0] e1;

  always #5 clock = ~clock;

  lpm_inv_skid #(.lpm_width(8), .lpm_invert("ON")) dut8 (
    .clock(clock), .aclr_n(aclr_n), .sclr(sc8),
    .data_valid(dv8), .data(d8), .data_ready(dr8),
    .result_valid(rv8), .result(res8), .result_ready(rr8), .usedw(uw8)
  );

  lpm_inv_skid #(.lpm_width(1), .lpm_invert("OFF")) dut1 (
    .clock(clock), .aclr_n(aclr_n), .sclr(sc1),
    .data_valid(dv1), .data(d1), .data_ready(dr1),
    .result_valid(rv1), .result(res1), .result_ready(rr1), .usedw(uw1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clock) begin
    chk("usedw8", 32'(uw8), 32'(mc8));
    chk("valid8", 32'(rv8), 32'(mc8 != 0));
    chk("ready8", 32'(dr8), 32'(aclr_n && (mc8 != 2)));
    if (rv8) begin
      if (q8.size() == 0) begin
        chk("underflow8", 32'(rv8), 32'd0);
      end else if (rr8) begin
        e8 = q8.pop_front();
        chk("result8", 32'(res8), 32'(e8));
      end else begin
        chk("head8", 32'(res8), 32'(q8[0]));
      end
    end
  end

  // Monitor for the 1-bit instance.
  always @(negedge clock) begin
    chk("usedw1", 32'(uw1), 32'(mc1));
    chk("valid1", 32'(rv1), 32'(mc1 != 0));
    chk("ready1", 32'(dr1), 32'(aclr_n && (mc1 != 2)));
    if (rv1) begin
      if (q1.size() == 0) begin
        chk("underflow1", 32'(rv1), 32'd0);
      end else if (rr1) begin
        e1 = q1.pop_front();
        chk("result1", 32'(res1), 32'(e1));
      end else begin
        chk("head1", 32'(res1), 32'(q1[0]));
      end
    end
  end

  // Drive one cycle on the 8-bit instance. Exp is the hand-computed stored word.
  task automatic step8(input logic v, input logic [7:0] d, input logic r,
                       input logic s, input logic [7:0] exp);
    int pre;
    dv8 = v; d8 = d; rr8 = r; sc8 = s;
    @(posedge clock);
    pre = mc8;
    if (s) begin
      mc8 = 0;
      q8.delete();
    end else begin
      if (v && (pre < 2)) begin
        q8.push_back(exp);
        mc8++;
      end
      if (r && (pre > 0)) mc8--;
    end
    #1;
  endtask

  // Drive one cycle on the 1-bit instance.
  task automatic step1(input logic v, input logic [0:0] d, input logic r,
                       input logic s, input logic [0:0] exp);
    int pre;
    dv1 = v; d1 = d; rr1 = r; sc1 = s;
    @(posedge clock);
    pre = mc1;
    if (s) begin
      mc1 = 0;
      q1.delete();
    end else begin
      if (v && (pre < 2)) begin
        q1.push_back(exp);
        mc1++;
      end
      if (r && (pre > 0)) mc1--;
    end
    #1;
  endtask

  initial begin
    logic       rv;
    logic [0:0] rd;
    logic       rr;
    logic       rs;
    aclr_n = 1'b0;
    sc8 = 1'b0; dv8 = 1'b0; d8 = 8'h00; rr8 = 1'b0;
    sc1 = 1'b0; dv1 = 1'b0; d1 = 1'b0;  rr1 = 1'b0;
    repeat (2) @(posedge clock);
    #2 aclr_n = 1'b1;
    #1;
    chk("rst_usedw", 32'(uw8), 32'd0);
    chk("rst_valid", 32'(rv8), 32'd0);
    chk("rst_result", 32'(res8), 32'd0);
    chk("rst_ready", 32'(dr8), 32'd1);

    // Back-to-back stream with inversion and no bubbles.
    step8(1'b1, 8'h00, 1'b1, 1'b0, 8'hFF);
    step8(1'b1, 8'h5A, 1'b1, 1'b0, 8'hA5);
    step8(1'b1, 8'hFF, 1'b1, 1'b0, 8'h00);
    step8(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    step8(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // Backpressure: fill, hold 0x33 off, then drain in order.
    step8(1'b1, 8'h11, 1'b0, 1'b0, 8'hEE);
    step8(1'b1, 8'h22, 1'b0, 1'b0, 8'hDD);
    step8(1'b1, 8'h33, 1'b0, 1'b0, 8'hCC);
    chk("bp_hold", 32'(res8), 32'h0000_00EE);
    chk("bp_ready", 32'(dr8), 32'd0);
    step8(1'b1, 8'h33, 1'b0, 1'b0, 8'hCC);
    step8(1'b1, 8'h33, 1'b1, 1'b0, 8'hCC);
    step8(1'b1, 8'h33, 1'b1, 1'b0, 8'hCC);
    step8(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    step8(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // Simultaneous push and pop while one word is held.
    step8(1'b1, 8'h01, 1'b1, 1'b0, 8'hFE);
    step8(1'b1, 8'h02, 1'b1, 1'b0, 8'hFD);
    step8(1'b1, 8'h03, 1'b1, 1'b0, 8'hFC);
    step8(1'b1, 8'h04, 1'b1, 1'b0, 8'hFB);
    step8(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    step8(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // sclr together with a push and a pop while full.
    step8(1'b1, 8'hA0, 1'b0, 1'b0, 8'h5F);
    step8(1'b1, 8'hA1, 1'b0, 1'b0, 8'h5E);
    step8(1'b1, 8'h77, 1'b1, 1'b1, 8'h88);
    chk("sclr_usedw", 32'(uw8), 32'd0);
    chk("sclr_valid", 32'(rv8), 32'd0);
    chk("sclr_result", 32'(res8), 32'd0);
    step8(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    step8(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    step8(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // Asynchronous clear while full, then a push on the first edge after release.
    step8(1'b1, 8'hC0, 1'b0, 1'b0, 8'h3F);
    step8(1'b1, 8'hC1, 1'b0, 1'b0, 8'h3E);
    dv8 = 1'b0; rr8 = 1'b0;
    #2 aclr_n = 1'b0;
    mc8 = 0; q8.delete();
    mc1 = 0; q1.delete();
    #1;
    chk("aclr_usedw", 32'(uw8), 32'd0);
    chk("aclr_valid", 32'(rv8), 32'd0);
    chk("aclr_result", 32'(res8), 32'd0);
    chk("aclr_ready", 32'(dr8), 32'd0);
    @(posedge clock);
    #2 aclr_n = 1'b1;
    #1;
    chk("release_ready", 32'(dr8), 32'd1);
    step8(1'b1, 8'hE7, 1'b1, 1'b0, 8'h18);
    step8(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    step8(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Pass-through, width 1.
    step1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random valid/ready soak against the reference queue.
    for (int i = 0; i < 400; i++) begin
      rv = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 39) == 0);
      step1(rv, rd, rr, rs, rd);
    end
    step1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    chk("drain8", 32'(q8.size()), 32'd0);
    chk("drain1", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
